seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Time-multiplexed seven-segment display driver, parametrised in digit count, scan rate and output polarity.
- Contains the scan prescaler, digit sequencer and double-buffered display registers.
- Selectable modes: hex decode per nibble, or graphic (raw segment byte per digit).
- Adds leading-zero blanking, per-digit blink and frame-synchronous data update.
- Sits between the CPU's display I/O register and the board anode/segment pins.

Parameters:
N_DIGITS, 8, number of digits scanned (2..16)
SCAN_DIV_BITS, 16, prescaler width; each digit is lit for 2^SCAN_DIV_BITS clocks
BLINK_DIV_BITS, 6, blink counter width in scan ticks; blink phase is its MSB
ACTIVE_LOW, 1, 1: an/seg are low-true; 0: high-true

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load  in  1  one-cycle strobe; captures data_in, graphic_in, dp_in, blink_mask, mode, lz_en
mode  in  1  0 = hex decode, 1 = graphic
lz_en  in  1  leading-zero blanking enable (hex mode only)
data_in  in  4*N_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = rightmost)
graphic_in  in  8*N_DIGITS  raw segment byte per digit, active-high, {dp,g,f,e,d,c,b,a}
dp_in  in  N_DIGITS  decimal points (hex mode)
blink_mask  in  N_DIGITS  1 = digit blinks
an  out  N_DIGITS  anode enables, one-hot (polarity per ACTIVE_LOW)
seg  out  8  {dp,g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (rst=1 at a clk edge) clears:
  - prescaler cnt, digit index idx, blink counter, active/pending registers, pending flag;
  - an = all off, seg = all off (all ones if ACTIVE_LOW, else zero), frame_done = 0.
- Reset mid-scan aborts immediately. No load survives reset.
- Prescaler:
  - cnt increments every clock, wrapping at 2^SCAN_DIV_BITS-1.
  - tick = (cnt == all ones).
- On tick:
  - idx <= (idx == N_DIGITS-1) ? 0 : idx+1.
  - blink counter increments (wraps).
- frame_done = 1 for exactly the cycle after the tick that wraps idx from N_DIGITS-1 to 0.
- Double buffering:
  - load copies inputs into pending and sets the pending flag.
  - A load while pending is set overwrites the pending contents.
  - At a wrap tick with pending set: active <= pending, flag cleared.
  - If load coincides with the wrap tick: the load's inputs go directly to active, and the flag clears.
  - Displayed data therefore never changes mid-frame.
- Outputs are registered and recomputed every clock from the current idx and active registers. A new idx appears on an/seg one clock after it is updated.
- an: only bit idx asserted.
- seg, hex mode:
  - Hex decode, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - seg[7] = dp_in bit idx.
- seg, graphic mode: seg = graphic byte idx unchanged. lz_en and dp_in are ignored.
- Leading-zero blanking (hex mode, lz_en=1):
  - Digit i is blanked if nibbles N_DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked.
  - The decimal point of a blanked digit is still shown.
- Blink: when the blink counter MSB = 1 and blink_mask[idx] = 1, all 8 segments are off. The anode still scans.
- Priority: blink blank > lz blank > decode.
- Polarity: final seg and an are inverted when ACTIVE_LOW=1.
- The blink counter is not reset by load.

Test Plan:
(N_DIGITS=4, SCAN_DIV_BITS=2, BLINK_DIV_BITS=3, ACTIVE_LOW=1)
1. Reset then release -> an=4'b1111 and seg=8'hFF during reset; 1 clk after release an=4'b1110; an=4'b1101 after 4 more clks; frame_done pulses once every 16 clks.
2. load data_in=16'h12AF, mode=0, dp_in=0, after reset -> from next frame, seg per digit 0..3 = 8'h8E, 8'h88, 8'hA4, 8'hF9 (F, A, 2, 1, inverted).
3. lz_en=1, data_in=16'h0040, dp_in=4'b1000 -> digit3 seg=8'h7F (dp only); digit2 seg=8'hFF; digit1 seg=8'h99; digit0 seg=8'hC0. With data_in=16'h0000: digit0 seg=8'hC0, digits 1-3 seg=8'hFF.
4. Mid-frame load of 16'h1111 while 16'h2222 is active -> remaining digits of the current frame still show '2' (8'hA4); every digit shows '1' (8'hF9) from the clk after frame_done. Repeat with load on the wrap tick -> new value is shown in the immediately starting frame.
5. mode=1, graphic_in byte0=8'h80, blink_mask=4'b0001 -> digit0 seg=8'h7F for 4 scan ticks, then 8'hFF for 4 scan ticks (blink period 8 ticks = 32 clks); other digits are unaffected.
6. Assert rst mid-scan at idx=2 with pending set -> next cycle an/seg all off; after release digit0 is scanned with blank data and the pending load is discarded.

Source files
------------

// File: rtl/seg_scan_if.sv
// CPU-side display register bus and board-side anode/segment pins of seg_scan_driver.
interface seg_scan_if #(
   parameter int N_DIGITS = 8
);
   logic                  load;
   logic                  mode;
   logic                  lz_en;
   logic [4*N_DIGITS-1:0] data_in;
   logic [8*N_DIGITS-1:0] graphic_in;
   logic [N_DIGITS-1:0]   dp_in;
   logic [N_DIGITS-1:0]   blink_mask;
   logic [N_DIGITS-1:0]   an;
   logic [7:0]            seg;
   logic                  frame_done;

   modport master (
      output load, mode, lz_en, data_in, graphic_in, dp_in, blink_mask,
      input  an, seg, frame_done
   );

   modport slave (
      input  load, mode, lz_en, data_in, graphic_in, dp_in, blink_mask,
      output an, seg, frame_done
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: prescaler, digit sequencer, double-buffered
// display data, hex/graphic decode with leading-zero blanking and per-digit blink.
module seg_scan_driver #(
   parameter int N_DIGITS       = 8,
   parameter int SCAN_DIV_BITS  = 16,
   parameter int BLINK_DIV_BITS = 6,
   parameter bit ACTIVE_LOW     = 1'b1
) (
   input logic      clk,
   input logic      rst,
   seg_scan_if.slave bus
);
   localparam int                  IDX_W    = $clog2(N_DIGITS);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_DIGITS - 1);
   localparam logic [7:0]          SEG_INV  = {8{ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] AN_INV   = {N_DIGITS{ACTIVE_LOW}};

   typedef struct packed {
      logic [4*N_DIGITS-1:0] data;
      logic [8*N_DIGITS-1:0] gfx;
      logic [N_DIGITS-1:0]   dp;
      logic [N_DIGITS-1:0]   blink;
      logic                  mode;
      logic                  lz;
   } disp_t;

   logic [SCAN_DIV_BITS-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [BLINK_DIV_BITS-1:0] blink_q, blink_d;
   disp_t                     act_q, act_d, pend_q, pend_d;
   logic                      pend_flag_q, pend_flag_d;
   logic [N_DIGITS-1:0]       an_q, an_d;
   logic [7:0]                seg_q, seg_d;
   logic                      frame_done_q, frame_done_d;

   disp_t               in_s;
   logic                tick, wrap;
   logic [3:0]          nib;
   logic [7:0]          gbyte;
   logic                dp_bit, bm_bit, lzb, all_zero;
   logic [N_DIGITS-1:0] lz_blank, an_hi;
   logic [7:0]          seg_hi;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   always_comb begin
      in_s.data  = bus.data_in;
      in_s.gfx   = bus.graphic_in;
      in_s.dp    = bus.dp_in;
      in_s.blink = bus.blink_mask;
      in_s.mode  = bus.mode;
      in_s.lz    = bus.lz_en;

      tick         = &cnt_q;
      wrap         = tick && (idx_q == LAST_IDX);
      cnt_d        = cnt_q + SCAN_DIV_BITS'(1);
      idx_d        = idx_q;
      blink_d      = blink_q;
      frame_done_d = wrap;
      if (tick) begin
         idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
         blink_d = blink_q + BLINK_DIV_BITS'(1);
      end

      // Active data only changes on the frame wrap; a load landing on the wrap skips pending.
      act_d       = act_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      if (wrap) begin
         if (bus.load)        act_d = in_s;
         else if (pend_flag_q) act_d = pend_q;
         pend_flag_d = 1'b0;
      end else if (bus.load) begin
         pend_d      = in_s;
         pend_flag_d = 1'b1;
      end

      all_zero = 1'b1;
      lz_blank = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         all_zero    = all_zero & (act_q.data[4*i +: 4] == 4'h0);
         lz_blank[i] = all_zero & (i != 0);
      end

      nib    = '0;
      gbyte  = '0;
      dp_bit = 1'b0;
      bm_bit = 1'b0;
      lzb    = 1'b0;
      an_hi  = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib      = act_q.data[4*i +: 4];
            gbyte    = act_q.gfx[8*i +: 8];
            dp_bit   = act_q.dp[i];
            bm_bit   = act_q.blink[i];
            lzb      = lz_blank[i];
            an_hi[i] = 1'b1;
         end
      end

      if (act_q.mode)           seg_hi = gbyte;
      else if (act_q.lz && lzb) seg_hi = {dp_bit, 7'h00};
      else                      seg_hi = {dp_bit, hex7(nib)};
      if (blink_q[BLINK_DIV_BITS-1] && bm_bit) seg_hi = 8'h00;

      seg_d = seg_hi ^ SEG_INV;
      an_d  = an_hi ^ AN_INV;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         blink_q      <= '0;
         act_q        <= '0;
         pend_q       <= '0;
         pend_flag_q  <= 1'b0;
         an_q         <= AN_INV;
         seg_q        <= SEG_INV;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         blink_q      <= blink_d;
         act_q        <= act_d;
         pend_q       <= pend_d;
         pend_flag_q  <= pend_flag_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_done = frame_done_q;
endmodule
